// File: rtl/pipelined_rca_adder.sv
// WIDTH-bit a+b+cin split into STAGES registered ripple-carry slices, valid/ready on both sides.
// Define ADDER_OVERFLOW_EN to add a registered signed-overflow output (ovf) aligned with sum.
module pipelined_rca_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int SLICE = WIDTH / STAGES;

  // One shared enable: the whole pipe moves or the whole pipe holds.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SLICE;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]      a_in, b_in;
    logic                c_in, v_in;
    logic [SLICE-1:0]    slice_sum;
    logic [SLICE:0]      carry;
    logic [LO+SLICE-1:0] s_d, s_q;
    logic                c_q, v_q;

    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = b;
      assign c_in = cin;
      assign v_in = in_valid;
      assign s_d  = slice_sum;
    end else begin : g_body
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      // Lower sum bits ride along so every result bit exits in the same cycle.
      assign s_d  = {slice_sum, g_stage[k-1].s_q};
    end

    always_comb begin
      slice_sum = '0;
      carry     = '0;
      carry[0]  = c_in;
      for (int i = 0; i < SLICE; i++) begin
        slice_sum[i] = a_in[i] ^ b_in[i] ^ carry[i];
        carry[i+1]   = (a_in[i] & b_in[i]) | (carry[i] & (a_in[i] ^ b_in[i]));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        s_q <= s_d;
        c_q <= carry[SLICE];
        v_q <= v_in;
      end
    end

    // Operand skew: bits not yet consumed wait here for the next slice.
    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SLICE-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[REM-1:SLICE];
          b_q <= b_in[REM-1:SLICE];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;

`ifdef ADDER_OVERFLOW_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= g_stage[STAGES-1].carry[SLICE-1] ^ g_stage[STAGES-1].carry[SLICE];
    end
  end
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed bench for pipelined_rca_adder (WIDTH=16, STAGES=4); ovf checks only with ADDER_OVERFLOW_EN.
module tb_pipelined_rca_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef ADDER_OVERFLOW_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  pipelined_rca_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef ADDER_OVERFLOW_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  localparam int N = 9;
  vec_t vt[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input vec_t x);
    in_valid = v;
    a        = x.a;
    b        = x.b;
    cin      = x.cin;
  endtask

  task automatic check_result(input string name, input vec_t x);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_sum"}, {16'd0, sum}, {16'd0, x.s});
    check({name, "_cout"}, {31'd0, cout}, {31'd0, x.co});
`ifdef ADDER_OVERFLOW_EN
    check({name, "_ovf"}, {31'd0, ovf}, {31'd0, x.ov});
`endif
  endtask

  vec_t idle;

  initial begin
    vt[0] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[3] = '{16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0};
    vt[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vt[6] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[7] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[8] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    idle  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    // Reset state
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, idle);
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
`ifdef ADDER_OVERFLOW_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    #10 rst_n = 1'b1;
    cyc();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Exact latency with full carry propagation
    drive(1'b1, vt[0]);
    cyc();
    drive(1'b0, idle);
    for (int c = 1; c < 4; c++) begin
      check("lat_early_valid", {31'd0, out_valid}, 32'd0);
      cyc();
    end
    check_result("lat_carry", vt[0]);
    cyc();
    check("lat_drain", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream: simultaneous input and output transfers
    for (int c = 0; c < N + 4; c++) begin
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (c >= 4) check_result("stream", vt[c-4]);
      else        check("stream_idle", {31'd0, out_valid}, 32'd0);
      if (c < N) drive(1'b1, vt[c]);
      else       drive(1'b0, idle);
      cyc();
    end
    check("stream_drain", {31'd0, out_valid}, 32'd0);

    // Backpressure: stall three cycles with X at the output, Y and Z queued
    for (int c = 0; c < 4; c++) begin
      if (c < 3) drive(1'b1, vt[c+1]);
      else       drive(1'b0, idle);
      cyc();
    end
    check_result("bp_first", vt[1]);
    out_ready = 1'b0;
    #1;
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      cyc();
      check_result("bp_hold", vt[1]);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check_result("bp_x", vt[1]);
    cyc();
    check_result("bp_y", vt[2]);
    cyc();
    check_result("bp_z", vt[3]);
    cyc();
    check("bp_no_dup", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with operations in flight
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, vt[c+4]);
      cyc();
    end
    drive(1'b0, idle);
    check_result("rst_pre", vt[4]);
    #2 rst_n = 1'b0;
    #1;
    check("rstm_out_valid", {31'd0, out_valid}, 32'd0);
    check("rstm_sum", {16'd0, sum}, 32'd0);
    check("rstm_cout", {31'd0, cout}, 32'd0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      check("rstm_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    // Bubbles: in_valid 1,0,1,0 -> out_valid 1,0,1,0 four cycles later
    for (int c = 0; c < 8; c++) begin
      if (c == 4) check_result("bub0", vt[5]);
      if (c == 5) check("bub1_valid", {31'd0, out_valid}, 32'd0);
      if (c == 6) check_result("bub2", vt[6]);
      if (c == 7) check("bub3_valid", {31'd0, out_valid}, 32'd0);
      if (c == 0)      drive(1'b1, vt[5]);
      else if (c == 2) drive(1'b1, vt[6]);
      else             drive(1'b0, idle);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
